// File: rtl/counter_pkg.sv
// Shared types, constants and helpers for the preset up/down counter.
//   seg7_t       : one 7-segment digit, active-low, bit0=a .. bit6=g
//   SEG_DIGIT    : segment patterns for decimal digits 0..9
//   SEG_BLANK    : all segments off
//   bcd_to_seg7  : BCD nibble to segment pattern (non-decimal codes blank)
package counter_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    localparam seg7_t SEG_BLANK = 7'b1111111;

    function automatic seg7_t bcd_to_seg7(input logic [3:0] bcd);
        seg7_t s;
        case (bcd)
            4'd0:    s = SEG_DIGIT[0];
            4'd1:    s = SEG_DIGIT[1];
            4'd2:    s = SEG_DIGIT[2];
            4'd3:    s = SEG_DIGIT[3];
            4'd4:    s = SEG_DIGIT[4];
            4'd5:    s = SEG_DIGIT[5];
            4'd6:    s = SEG_DIGIT[6];
            4'd7:    s = SEG_DIGIT[7];
            4'd8:    s = SEG_DIGIT[8];
            4'd9:    s = SEG_DIGIT[9];
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw push-button conditioning: 2-FF synchroniser, debouncer and
// rising-edge pulse generator.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   btn_raw_i  : raw asynchronous button level
//   pulse_o    : one-cycle pulse on each accepted press
module button_conditioner #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    output logic pulse_o
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] RUN_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          db_q, db_d;
    logic          db_prev_q;
    logic [CW-1:0] run_q, run_d;

    // The level flips on the DEB_CYCLES-th consecutive mismatching cycle;
    // any matching cycle restarts the run.
    always_comb begin
        db_d  = db_q;
        run_d = '0;
        if (sync2_q != db_q) begin
            if (run_q == RUN_LAST) begin
                db_d = sync2_q;
            end else begin
                run_d = run_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            run_q     <= '0;
        end else begin
            sync1_q   <= btn_raw_i;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            run_q     <= run_d;
        end
    end

    assign pulse_o = db_q & ~db_prev_q;

endmodule

// File: rtl/preset_updown_counter.sv
// Button-driven up/down counter with three presets, wrap/saturate
// boundary mode and a decimal 7-segment readout.
//   clk, rst_n            : system clock, asynchronous active-low reset
//   inc, dec              : raw step buttons
//   num1, num2, num3      : raw preset-load buttons
//   sat                   : 0 = wrap at boundaries, 1 = saturate
//   count                 : current value
//   lim                   : one-cycle pulse when a step hits a boundary
//   at_zero, at_max       : count == 0, count == 2^N-1
//   seg                   : DIGITS x 7 active-low segments, digit 0 lowest
module preset_updown_counter
    import counter_pkg::*;
#(
    parameter int N          = 6,
    parameter int DIGITS     = 2,
    parameter int DEB_CYCLES = 4,
    parameter int PRESET1    = 1,
    parameter int PRESET2    = 2 ** (N - 1),
    parameter int PRESET3    = 2 ** N - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  num1,
    input  logic                  num2,
    input  logic                  num3,
    input  logic                  sat,
    output logic [N-1:0]          count,
    output logic                  lim,
    output logic                  at_zero,
    output logic                  at_max,
    output logic [DIGITS*7-1:0]   seg
);

    function automatic longint pow10(input int e);
        longint r;
        r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    if (((longint'(1) << N) - 1) >= pow10(DIGITS)) begin : g_digits_check
        $error("DIGITS too small to display 2^N-1");
    end
    if (DEB_CYCLES < 1) begin : g_deb_check
        $error("DEB_CYCLES must be at least 1");
    end

    localparam logic [N-1:0] P1 = PRESET1[N-1:0];
    localparam logic [N-1:0] P2 = PRESET2[N-1:0];
    localparam logic [N-1:0] P3 = PRESET3[N-1:0];
    localparam logic [N-1:0] MAXV = '1;

    // Button order: 0=inc 1=dec 2=num1 3=num2 4=num3
    logic [4:0] btn_raw;
    logic [4:0] ev;

    assign btn_raw = {num3, num2, num1, dec, inc};

    for (genvar b = 0; b < 5; b++) begin : g_btn
        button_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond (
            .clk       (clk),
            .rst_n     (rst_n),
            .btn_raw_i (btn_raw[b]),
            .pulse_o   (ev[b])
        );
    end

    logic [N-1:0] count_q, count_d;
    logic         lim_q, lim_d;
    logic [N:0]   up, dn;

    // Carry/borrow comes from the extra top bit of the widened result.
    assign up = {1'b0, count_q} + {{N{1'b0}}, 1'b1};
    assign dn = {1'b0, count_q} - {{N{1'b0}}, 1'b1};

    always_comb begin
        count_d = count_q;
        lim_d   = 1'b0;
        if (ev[2]) begin
            count_d = P1;
        end else if (ev[3]) begin
            count_d = P2;
        end else if (ev[4]) begin
            count_d = P3;
        end else if (ev[0] && !ev[1]) begin
            lim_d = up[N];
            if (!(up[N] && sat)) count_d = up[N-1:0];
        end else if (ev[1] && !ev[0]) begin
            lim_d = dn[N];
            if (!(dn[N] && sat)) count_d = dn[N-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            lim_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            lim_q   <= lim_d;
        end
    end

    assign count   = count_q;
    assign lim     = lim_q;
    assign at_zero = (count_q == '0);
    assign at_max  = (count_q == MAXV);

    // Double-dabble: add 3 to any BCD digit >= 5 before each shift.
    function automatic logic [4*DIGITS-1:0] bin_to_bcd(input logic [N-1:0] bin);
        logic [4*DIGITS-1:0] bcd;
        bcd = '0;
        for (int i = N - 1; i >= 0; i--) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (bcd[4*d +: 4] >= 4'd5) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
            bcd = {bcd[4*DIGITS-2:0], bin[i]};
        end
        return bcd;
    endfunction

    logic [4*DIGITS-1:0] bcd;
    assign bcd = bin_to_bcd(count_q);

    for (genvar d = 0; d < DIGITS; d++) begin : g_seg
        assign seg[7*d +: 7] = bcd_to_seg7(bcd[4*d +: 4]);
    end

endmodule

// File: tb/tb_preset_updown_counter.sv
module tb_preset_updown_counter;

    localparam logic [4:0] B_INC  = 5'b00001;
    localparam logic [4:0] B_DEC  = 5'b00010;
    localparam logic [4:0] B_NUM1 = 5'b00100;
    localparam logic [4:0] B_NUM2 = 5'b01000;
    localparam logic [4:0] B_NUM3 = 5'b10000;
    localparam int LAT = 7;

    localparam logic [6:0] SEG_TB [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inc = 1'b0, dec = 1'b0, num1 = 1'b0, num2 = 1'b0, num3 = 1'b0;
    logic        sat = 1'b0;
    logic [5:0]  count;
    logic        lim, at_zero, at_max;
    logic [13:0] seg;

    preset_updown_counter #(
        .N(6), .DIGITS(2), .DEB_CYCLES(4), .PRESET1(1), .PRESET2(32), .PRESET3(63)
    ) dut (
        .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec),
        .num1(num1), .num2(num2), .num3(num3), .sat(sat),
        .count(count), .lim(lim), .at_zero(at_zero), .at_max(at_max), .seg(seg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int cnt;
        bit lim;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [13:0] seg_of(input int v);
        return {SEG_TB[v / 10], SEG_TB[v % 10]};
    endfunction

    task automatic drive(input logic [4:0] m);
        {num3, num2, num1, dec, inc} = m;
    endtask

    task automatic push(input int c, input int v, input bit l);
        exp_t e;
        e.cyc = c;
        e.cnt = v;
        e.lim = l;
        q.push_back(e);
    endtask

    task automatic press(input logic [4:0] m, input bit expect_ev, input int v, input bit l);
        @(negedge clk);
        if (expect_ev) push(cyc + LAT, v, l);
        drive(m);
        repeat (10) @(negedge clk);
        drive(5'b0);
        repeat (12) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_lim"}, int'(lim), 0);
        chk({tag, "_at_zero"}, int'(at_zero), 1);
        chk({tag, "_at_max"}, int'(at_max), 0);
        chk({tag, "_seg"}, int'(seg), int'(seg_of(0)));
    endtask

    // Monitor: an output event is a count change or a lim pulse. Every
    // out-of-reset cycle checks that an event occurs exactly when one is due.
    initial begin
        int   prev_cnt;
        exp_t e;
        prev_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_cnt = int'(count);
            end else begin
                bit ev_seen;
                bit due;
                ev_seen = (int'(count) != prev_cnt) || lim;
                due = (q.size() > 0) && (q[0].cyc == cyc);
                chk("event_timing", int'(ev_seen), int'(due));
                if (due) begin
                    e = q.pop_front();
                    chk("count", int'(count), e.cnt);
                    chk("lim", int'(lim), int'(e.lim));
                    chk("at_zero", int'(at_zero), int'(e.cnt == 0));
                    chk("at_max", int'(at_max), int'(e.cnt == 63));
                    chk("seg", int'(seg), int'(seg_of(e.cnt)));
                end
                prev_cnt = int'(count);
            end
        end
    end

    initial begin
        // Reset with inc held during reset: no event afterwards.
        rst_n = 1'b0;
        drive(B_INC);
        repeat (3) @(negedge clk);
        #1 chk_reset_vals("reset");
        drive(5'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Wrap down from 0.
        sat = 1'b0;
        press(B_DEC, 1, 63, 1);

        // Saturate at max.
        sat = 1'b1;
        press(B_INC, 1, 63, 1);
        sat = 1'b0;

        // Reset mid-count.
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk_reset_vals("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Priority: load beats step, num1 beats num3.
        press(B_NUM2 | B_DEC, 1, 32, 0);
        press(B_NUM1 | B_NUM3, 1, 1, 0);
        press(B_NUM3, 1, 63, 0);
        press(B_INC, 1, 0, 1);

        // Bounce: two short highs, then a long hold -> one increment.
        @(negedge clk);
        drive(B_INC);
        repeat (2) @(negedge clk);
        drive(5'b0);
        repeat (2) @(negedge clk);
        drive(B_INC);
        repeat (2) @(negedge clk);
        drive(5'b0);
        repeat (2) @(negedge clk);
        push(cyc + LAT, 1, 0);
        drive(B_INC);
        repeat (100) @(negedge clk);
        drive(5'b0);
        repeat (12) @(negedge clk);

        // Count up to 10.
        for (int v = 2; v <= 10; v++) press(B_INC, 1, v, 0);

        // Simultaneous inc and dec: nothing happens.
        press(B_INC | B_DEC, 0, 0, 0);
        chk("simul_count", int'(count), 10);

        // Reset two cycles into a dec press, released during reset.
        @(negedge clk);
        drive(B_DEC);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        drive(5'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_count", int'(count), 0);

        // Saturate at zero.
        sat = 1'b1;
        press(B_DEC, 1, 0, 1);
        sat = 1'b0;

        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
